// File: rtl/his_reader_fsm_if.sv
// RAM read/clear port and downstream bin-stream handshake used by his_reader_fsm.
interface his_reader_fsm_if #(parameter int NB = 8, parameter int CNT_W = 16);
  logic             ram_rd_en;
  logic [NB:0]      ram_addr;
  logic [CNT_W-1:0] ram_rdata;
  logic             ram_wr_en;
  logic [CNT_W-1:0] ram_wdata;
  logic             bin_valid;
  logic             bin_ready;
  logic [CNT_W-1:0] bin_data;
  logic [NB-1:0]    bin_idx;
  logic             bin_last;

  modport master (
    output ram_rd_en, ram_addr, ram_wr_en, ram_wdata,
    input  ram_rdata,
    output bin_valid, bin_data, bin_idx, bin_last,
    input  bin_ready
  );

  modport slave (
    input  ram_rd_en, ram_addr, ram_wr_en, ram_wdata,
    output ram_rdata,
    input  bin_valid, bin_data, bin_idx, bin_last,
    output bin_ready
  );
endinterface

// File: rtl/his_reader_fsm.sv
// Histogram bank readout: 3 cycles/bin (4 with HIS_CLEAR_ON_READ_EN), first word 3 cycles after start,
// bin word frozen while bin_ready is low; tracks the peak bin (ties keep the lower index).
module his_reader_fsm #(
  parameter int NB    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             his_sel,
  his_reader_fsm_if.master bus,
  output logic [NB-1:0]    peak_idx,
  output logic [CNT_W-1:0] peak_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    OUT  = 3'd3,
    CLR  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [NB-1:0] IDX_MAX = '1;

  state_t           state, state_nxt;
  logic             bank, bank_nxt;
  logic [NB-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0] data_q, data_nxt;
  logic [NB-1:0]    bidx_q, bidx_nxt;
  logic             last_q, last_nxt;
  logic [NB-1:0]    pidx_nxt;
  logic [CNT_W-1:0] pcnt_nxt;
  logic             rd_c;
  logic             valid_c;
  logic [NB:0]      addr_c;
`ifdef HIS_CLEAR_ON_READ_EN
  logic             wr_c;
`endif

  always_ff @(posedge clk) begin
    if (!res) begin
      state    <= IDLE;
      bank     <= 1'b0;
      idx      <= '0;
      data_q   <= '0;
      bidx_q   <= '0;
      last_q   <= 1'b0;
      peak_idx <= '0;
      peak_cnt <= '0;
    end else begin
      state    <= state_nxt;
      bank     <= bank_nxt;
      idx      <= idx_nxt;
      data_q   <= data_nxt;
      bidx_q   <= bidx_nxt;
      last_q   <= last_nxt;
      peak_idx <= pidx_nxt;
      peak_cnt <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bank_nxt  = bank;
    idx_nxt   = idx;
    data_nxt  = data_q;
    bidx_nxt  = bidx_q;
    last_nxt  = last_q;
    pidx_nxt  = peak_idx;
    pcnt_nxt  = peak_cnt;
    rd_c      = 1'b0;
    valid_c   = 1'b0;
    addr_c    = '0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef HIS_CLEAR_ON_READ_EN
    wr_c      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          bank_nxt  = his_sel;
          idx_nxt   = '0;
          pidx_nxt  = '0;
          pcnt_nxt  = '0;
          state_nxt = RD;
        end
      end
      RD: begin
        busy      = 1'b1;
        rd_c      = 1'b1;
        addr_c    = {bank, idx};
        state_nxt = LAT;
      end
      LAT: begin
        busy      = 1'b1;
        data_nxt  = bus.ram_rdata;
        bidx_nxt  = idx;
        last_nxt  = (idx == IDX_MAX);
        state_nxt = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        valid_c = 1'b1;
        if (bus.bin_ready) begin
          // strict compare so an equal later bin never displaces the earlier peak
          if (data_q > peak_cnt) begin
            pcnt_nxt = data_q;
            pidx_nxt = bidx_q;
          end
`ifdef HIS_CLEAR_ON_READ_EN
          state_nxt = CLR;
`else
          if (last_q) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = RD;
          end
`endif
        end
      end
`ifdef HIS_CLEAR_ON_READ_EN
      CLR: begin
        busy   = 1'b1;
        wr_c   = 1'b1;
        addr_c = {bank, bidx_q};
        if (last_q) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = RD;
        end
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ram_rd_en = rd_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_wdata = '0;
`ifdef HIS_CLEAR_ON_READ_EN
  assign bus.ram_wr_en = wr_c;
`else
  assign bus.ram_wr_en = 1'b0;
`endif
  assign bus.bin_valid = valid_c;
  assign bus.bin_data  = data_q;
  assign bus.bin_idx   = bidx_q;
  assign bus.bin_last  = last_q;

endmodule

// File: tb/tb_his_reader_fsm.sv
// Scoreboard bench for his_reader_fsm: an NB=3 instance for sweep/back-pressure/clear/reset cases
// and an NB=8 instance for the full-width sweep.
module tb_his_reader_fsm;
  localparam int NB    = 3;
  localparam int CNT_W = 16;
  localparam int NBINS = 8;
`ifdef HIS_CLEAR_ON_READ_EN
  localparam bit CLR_EN  = 1'b1;
`else
  localparam bit CLR_EN  = 1'b0;
`endif
  localparam int PER_BIN = CLR_EN ? 4 : 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res, start, his_sel, busy, done;
  logic [NB-1:0]    peak_idx;
  logic [CNT_W-1:0] peak_cnt;
  logic             start8, his_sel8, busy8, done8;
  logic [7:0]       peak_idx8;
  logic [CNT_W-1:0] peak_cnt8;

  his_reader_fsm_if #(.NB(NB), .CNT_W(CNT_W)) bus ();
  his_reader_fsm_if #(.NB(8), .CNT_W(CNT_W)) bus8 ();

  his_reader_fsm #(.NB(NB), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .his_sel(his_sel), .bus(bus),
    .peak_idx(peak_idx), .peak_cnt(peak_cnt), .busy(busy), .done(done)
  );

  his_reader_fsm #(.NB(8), .CNT_W(CNT_W)) dut8 (
    .clk(clk), .res(res), .start(start8), .his_sel(his_sel8), .bus(bus8),
    .peak_idx(peak_idx8), .peak_cnt(peak_cnt8), .busy(busy8), .done(done8)
  );

  int total = 0;
  int bad   = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @cyc", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models with a bench-side load port
  logic [CNT_W-1:0] mem  [2*NBINS];
  logic [CNT_W-1:0] mem8 [512];
  logic             ld_en, ld8_en;
  logic [NB:0]      ld_addr;
  logic [8:0]       ld8_addr;
  logic [CNT_W-1:0] ld_data, ld8_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    if (ld8_en) mem8[ld8_addr] <= ld8_data;
    else if (bus8.ram_wr_en) mem8[bus8.ram_addr] <= bus8.ram_wdata;
    if (bus8.ram_rd_en) bus8.ram_rdata <= mem8[bus8.ram_addr];
  end

  typedef struct packed {
    logic [NB-1:0]    idx;
    logic [CNT_W-1:0] data;
    logic             last;
  } word_t;

  word_t            q[$];
  logic [CNT_W-1:0] exp_mem [2*NBINS];
  logic             cur_bank;
  int               done_cnt = 0, wr_cnt = 0, held_cnt = 0;
  logic             pend = 1'b0;
  logic [NB:0]      pend_addr;
  int               pend_cyc;

  // Scoreboard / protocol monitor for the NB=3 instance
  always @(negedge clk) begin
    word_t w;
    if (!res) begin
      pend = 1'b0;
    end else begin
      check("rd_wr_excl", bus.ram_rd_en & bus.ram_wr_en, 1'b0);
      if (CLR_EN) begin
        if (bus.ram_wr_en) begin
          check("wr_when", (pend && cyc == pend_cyc), 1'b1);
          check("wr_addr", bus.ram_addr, pend_addr);
          check("wr_data", bus.ram_wdata, 0);
          pend = 1'b0;
          wr_cnt++;
        end else if (pend && cyc >= pend_cyc) begin
          check("wr_miss", bus.ram_wr_en, 1'b1);
          pend = 1'b0;
        end
      end else begin
        check("wr_off", bus.ram_wr_en, 1'b0);
      end
      if (bus.bin_valid && bus.bin_ready) begin
        if (q.size() == 0) begin
          check("extra_word", q.size(), 1);
        end else begin
          w = q.pop_front();
          check("bin_idx", bus.bin_idx, w.idx);
          check("bin_data", bus.bin_data, w.data);
          check("bin_last", bus.bin_last, w.last);
        end
        pend      = 1'b1;
        pend_addr = {cur_bank, bus.bin_idx};
        pend_cyc  = cyc + 1;
      end else if (bus.bin_valid && q.size() > 0) begin
        check("hold_data", bus.bin_data, q[0].data);
        check("hold_idx", bus.bin_idx, q[0].idx);
        check("hold_rd", bus.ram_rd_en, 1'b0);
        held_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [CNT_W-1:0] exp8(input int i);
    return (i == 255) ? 16'hFFFF : CNT_W'((i * 37) % 1000);
  endfunction

  int n8 = 0;
  always @(negedge clk) begin
    if (res && bus8.bin_valid && bus8.bin_ready) begin
      check("w8_idx", bus8.bin_idx, n8);
      check("w8_data", bus8.bin_data, exp8(n8));
      check("w8_last", bus8.bin_last, (n8 == 255));
      n8++;
    end
  end

  task automatic load_bank(input logic b, input logic [CNT_W-1:0] v [NBINS]);
    for (int i = 0; i < NBINS; i++) begin
      @(posedge clk); #1;
      ld_en   = 1'b1;
      ld_addr = {b, NB'(i)};
      ld_data = v[i];
      exp_mem[{b, NB'(i)}] = v[i];
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_done"}, done, 1'b0);
    check({p, "_valid"}, bus.bin_valid, 1'b0);
    check({p, "_data"}, bus.bin_data, 0);
    check({p, "_idx"}, bus.bin_idx, 0);
    check({p, "_last"}, bus.bin_last, 1'b0);
    check({p, "_rd"}, bus.ram_rd_en, 1'b0);
    check({p, "_wr"}, bus.ram_wr_en, 1'b0);
    check({p, "_addr"}, bus.ram_addr, 0);
    check({p, "_pidx"}, peak_idx, 0);
    check({p, "_pcnt"}, peak_cnt, 0);
  endtask

  // mode: 0 plain, 1 back-pressure on idx 1, 2 start while busy, 3 reset in OUT of idx 3
  task automatic run_sweep(input logic b, input int mode);
    int t0, exp_done, d0, w0, h0;
    logic [CNT_W-1:0] pc;
    logic [NB-1:0]    pi;
    bit got;
    pc = '0; pi = '0; got = 1'b0;
    for (int i = 0; i < NBINS; i++) begin
      q.push_back({NB'(i), exp_mem[{b, NB'(i)}], (i == NBINS - 1)});
      if (exp_mem[{b, NB'(i)}] > pc) begin
        pc = exp_mem[{b, NB'(i)}];
        pi = NB'(i);
      end
    end
    cur_bank = b;
    d0 = done_cnt; w0 = wr_cnt; h0 = held_cnt;
    exp_done = PER_BIN * NBINS + 1 + ((mode == 1) ? 4 : 0);
    @(posedge clk); #1;
    start = 1'b1; his_sel = b; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (mode == 1 && cyc == t0 + 3 + PER_BIN) bus.bin_ready = 1'b0;
      if (mode == 1 && cyc == t0 + 7 + PER_BIN) bus.bin_ready = 1'b1;
      if (mode == 2 && cyc == t0 + 5) begin start = 1'b1; his_sel = ~b; end
      if (mode == 2 && cyc == t0 + 6) start = 1'b0;
      if (mode == 3 && cyc == t0 + 3 + 3 * PER_BIN) begin
        check("rst_in_out_valid", bus.bin_valid, 1'b1);
        check("rst_in_out_idx", bus.bin_idx, 3);
        res = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        check_idle("mid_rst");
        q.delete();
        if (CLR_EN) for (int i = 0; i < 3; i++) exp_mem[{b, NB'(i)}] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_stays_idle", busy | bus.ram_rd_en | bus.ram_wr_en, 1'b0);
        return;
      end
      if (done) begin
        got = 1'b1;
        check("done_cyc", cyc - t0, exp_done);
        break;
      end
    end
    if (!got) check("done_timeout", got, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("peak_idx", peak_idx, pi);
    check("peak_cnt", peak_cnt, pc);
    check("words_left", q.size(), 0);
    check("wr_count", wr_cnt - w0, CLR_EN ? NBINS : 0);
    if (mode == 1) check("held_cycles", held_cnt - h0, 4);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("peak_hold_idx", peak_idx, pi);
    check("peak_hold_cnt", peak_cnt, pc);
    q.delete();
    if (CLR_EN) for (int i = 0; i < NBINS; i++) exp_mem[{b, NB'(i)}] = '0;
  endtask

  logic [CNT_W-1:0] bank0_v [NBINS] = '{16'd5, 16'd0, 16'd9, 16'd2, 16'd9, 16'd1, 16'd0, 16'd3};
  logic [CNT_W-1:0] bank1_v [NBINS] = '{default: 16'd7};

  initial begin
    int t8;
    bit got8;
    res = 1'b0; start = 1'b0; his_sel = 1'b0; bus.bin_ready = 1'b1; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0;
    start8 = 1'b0; his_sel8 = 1'b0; bus8.bin_ready = 1'b1; ld8_en = 1'b0;
    ld8_addr = '0; ld8_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    res = 1'b1;

    load_bank(1'b0, bank0_v);
    load_bank(1'b1, bank1_v);
    run_sweep(1'b0, 0);              // basic: peak 2/9, done at T+25 (T+33 with clear)
    load_bank(1'b0, bank0_v);
    run_sweep(1'b0, 1);              // back-pressure on idx 1
    load_bank(1'b0, bank0_v);
    run_sweep(1'b0, 2);              // start while busy, flipped bank ignored
    run_sweep(1'b1, 0);              // bank 1 all 7s (cleared to 0 in clear build)
    run_sweep(1'b1, 0);              // readback of bank 1
    load_bank(1'b0, bank0_v);
    run_sweep(1'b0, 3);              // reset mid-sweep
    run_sweep(1'b0, 0);              // readback after reset

    // full-width sweep on the NB=8 instance
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      ld8_en = 1'b1; ld8_addr = 9'(i); ld8_data = exp8(i);
    end
    @(posedge clk); #1;
    ld8_en = 1'b0;
    start8 = 1'b1; t8 = cyc;
    @(posedge clk); #1;
    start8 = 1'b0;
    got8 = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        got8 = 1'b1;
        check("w8_done_cyc", cyc - t8, PER_BIN * 256 + 1);
        break;
      end
    end
    if (!got8) check("w8_done_timeout", got8, 1'b1);
    check("w8_peak_idx", peak_idx8, 255);
    check("w8_peak_cnt", peak_cnt8, 16'hFFFF);
    check("w8_words", n8, 256);
    repeat (2) @(posedge clk);
    #1;
    check("w8_no_wrap", busy8 | bus8.bin_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
